nand_op_scheduler: RTL

Time-multiplexed scheduler that shares one WIDTH-bit bank of sNAND primitives among NREQ requesters. Each requester asks for NOT, NAND, AND or OR on WIDTH-bit operands. The block arbitrates round-robin, latches the winner's operands, and sequences the shared NAND bank over 1–3 passes to build the requested function. This is the first clocked block in the gate-level chain; every pass result is formed only from sNAND evaluations.

---
 rtl/nand_op_scheduler.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/nand_op_scheduler.sv
// Shared sNAND bank scheduler: round-robin grant, then NOT/NAND/AND/OR over 1-3 NAND passes.
// Latency: gnt one edge after req is sampled in IDLE, done P edges after grant (P = 1,1,2,3).
// Backpressure: one op in flight; other requesters hold req until their gnt bit is seen.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   req[NREQ]         : per-requester request, held until granted
//   op[2*NREQ]        : per-requester op (00 NOT, 01 NAND, 10 AND, 11 OR)
//   a, b[WIDTH*NREQ]  : per-requester operands, packed by requester index
//   gnt[NREQ]         : one-hot, one cycle per accepted request
//   busy              : operation in progress
//   done              : one-cycle pulse, result/done_id valid while high
//   result, done_id   : last completed result and its owning requester
module nand_op_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        op,
  input  logic [WIDTH*NREQ-1:0]    a,
  input  logic [WIDTH*NREQ-1:0]    b,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int IDW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EVAL = 1'b1;

  localparam logic [1:0] OP_NOT  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_OR   = 2'b11;

  logic [0:0]       state_q,   state_d;
  logic [IDW-1:0]   last_q,    last_d;
  logic [IDW-1:0]   idx_q,     idx_d;
  logic [1:0]       op_q,      op_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] t0_q,      t0_d;
  logic [WIDTH-1:0] t1_q,      t1_d;
  logic [1:0]       pass_q,    pass_d;
  logic [NREQ-1:0]  gnt_q,     gnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [IDW-1:0]   done_id_q, done_id_d;

  // Round-robin search starting just after the last winner, wrapping.
  logic win_vld;
  int   win_int;
  int   cand;

  always_comb begin
    win_vld = 1'b0;
    win_int = 0;
    cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_int = cand;
      end
    end
  end

  // Operand steering into the single shared NAND bank for the current pass.
  logic [WIDTH-1:0] nand_x, nand_y, nand_out;
  logic             last_pass;

  always_comb begin
    nand_x    = a_q;
    nand_y    = a_q;
    last_pass = 1'b0;
    case (op_q)
      OP_NOT: begin
        nand_x    = a_q;
        nand_y    = a_q;
        last_pass = 1'b1;
      end
      OP_NAND: begin
        nand_x    = a_q;
        nand_y    = b_q;
        last_pass = 1'b1;
      end
      OP_AND: begin
        if (pass_q == 2'd0) begin
          nand_x = a_q;
          nand_y = b_q;
        end else begin
          nand_x = t0_q;
          nand_y = t0_q;
        end
        last_pass = (pass_q == 2'd1);
      end
      OP_OR: begin
        if (pass_q == 2'd0) begin
          nand_x = a_q;
          nand_y = a_q;
        end else if (pass_q == 2'd1) begin
          nand_x = b_q;
          nand_y = b_q;
        end else begin
          nand_x = t0_q;
          nand_y = t1_q;
        end
        last_pass = (pass_q == 2'd2);
      end
      default: begin
        nand_x    = a_q;
        nand_y    = a_q;
        last_pass = 1'b1;
      end
    endcase
  end

  assign nand_out = ~(nand_x & nand_y);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    idx_d     = idx_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    t0_d      = t0_q;
    t1_d      = t1_q;
    pass_d    = pass_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    done_id_d = done_id_q;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          idx_d   = IDW'(win_int);
          last_d  = IDW'(win_int);
          op_d    = op[2*win_int +: 2];
          a_d     = a[WIDTH*win_int +: WIDTH];
          b_d     = b[WIDTH*win_int +: WIDTH];
          gnt_d   = NREQ'(1) << win_int;
          pass_d  = 2'd0;
          busy_d  = 1'b1;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        pass_d = pass_q + 2'd1;
        // Intermediates only exist for multi-pass ops.
        if (pass_q == 2'd0 && (op_q == OP_AND || op_q == OP_OR)) begin
          t0_d = nand_out;
        end
        if (pass_q == 2'd1 && op_q == OP_OR) begin
          t1_d = nand_out;
        end
        if (last_pass) begin
          result_d  = nand_out;
          done_id_d = idx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= IDW'(NREQ - 1);
      idx_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      t0_q      <= '0;
      t1_q      <= '0;
      pass_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      pass_q    <= pass_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign done_id = done_id_q;

endmodule
